// File: rtl/block_nest_checker_if.sv
// Character stream and nesting-status bundle for block_nest_checker.
interface block_nest_checker_if #(
   parameter int unsigned DW = 5
);
   logic          valid;
   logic [7:0]    in;
   logic          result;
   logic [DW-1:0] depth;
   logic          error;
   logic          overflow;

   modport master (
      output valid,
      output in,
      input  result,
      input  depth,
      input  error,
      input  overflow
   );

   modport slave (
      input  valid,
      input  in,
      output result,
      output depth,
      output error,
      output overflow
   );
endinterface

// File: rtl/block_nest_checker.sv
// Streaming begin/end and fork/join nesting checker with a typed stack,
// sticky error/overflow flags and a combinational look-ahead result.
module block_nest_checker #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
   input logic                clk,
   input logic                reset,
   block_nest_checker_if.slave bus
);

   localparam logic [2:0] LenMax = 3'd6;

   logic [2:0]       len_q, len_d;
   logic [3:0]       cand_q, cand_d;  // {join, fork, end, begin}
   logic [DW-1:0]    sp_q, sp_d;
   logic [DEPTH-1:0] stack_q, stack_d;
   logic             error_q, error_d;
   logic             overflow_q, overflow_d;

   logic [7:0] ch;
   logic       is_delim;
   logic       open0, close0, open1, close1;
   logic       is_open, is_close;
   logic       top_type;
   logic       sp_empty, sp_full;
   logic       would_err;
   logic [DW:0] balance;

   function automatic logic [7:0] fold(input logic [7:0] c);
      if (c >= 8'h41 && c <= 8'h5A) begin
         return c | 8'h20;
      end
      return c;
   endfunction

   function automatic logic [2:0] kw_len(input logic [1:0] k);
      case (k)
         2'd0:    return 3'd5;
         2'd1:    return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   // Only consulted for pos < kw_len(k), so the default never reaches a match.
   function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] pos);
      case ({k, pos})
         {2'd0, 3'd0}: return "b";
         {2'd0, 3'd1}: return "e";
         {2'd0, 3'd2}: return "g";
         {2'd0, 3'd3}: return "i";
         {2'd0, 3'd4}: return "n";
         {2'd1, 3'd0}: return "e";
         {2'd1, 3'd1}: return "n";
         {2'd1, 3'd2}: return "d";
         {2'd2, 3'd0}: return "f";
         {2'd2, 3'd1}: return "o";
         {2'd2, 3'd2}: return "r";
         {2'd2, 3'd3}: return "k";
         {2'd3, 3'd0}: return "j";
         {2'd3, 3'd1}: return "o";
         {2'd3, 3'd2}: return "i";
         {2'd3, 3'd3}: return "n";
         default:      return 8'h00;
      endcase
   endfunction

   always_comb begin
      ch       = fold(bus.in);
      is_delim = (bus.in == 8'h20) || (bus.in == 8'h0A);

      open0    = cand_q[0] && (len_q == 3'd5);
      close0   = cand_q[1] && (len_q == 3'd3);
      open1    = cand_q[2] && (len_q == 3'd4);
      close1   = cand_q[3] && (len_q == 3'd4);
      is_open  = open0 || open1;
      is_close = close0 || close1;

      sp_empty = (sp_q == '0);
      sp_full  = (sp_q == DW'(DEPTH));

      top_type = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (sp_q == DW'(i + 1)) begin
            top_type = stack_q[i];
         end
      end

      would_err = (is_close && (sp_empty || (top_type != close1))) || (is_open && sp_full);
      balance   = {1'b0, sp_q} + (DW + 1)'(is_open) - (DW + 1)'(is_close);
   end

   always_comb begin
      len_d      = len_q;
      cand_d     = cand_q;
      sp_d       = sp_q;
      stack_d    = stack_q;
      error_d    = error_q;
      overflow_d = overflow_q;

      if (bus.valid && !error_q) begin
         if (is_delim) begin
            len_d  = 3'd0;
            cand_d = '1;
            if (is_open) begin
               if (sp_full) begin
                  error_d    = 1'b1;
                  overflow_d = 1'b1;
               end else begin
                  for (int i = 0; i < int'(DEPTH); i++) begin
                     if (sp_q == DW'(i)) begin
                        stack_d[i] = open1;
                     end
                  end
                  sp_d = sp_q + DW'(1);
               end
            end else if (is_close) begin
               if (sp_empty || (top_type != close1)) begin
                  error_d = 1'b1;
               end else begin
                  sp_d = sp_q - DW'(1);
               end
            end
         end else begin
            len_d = (len_q == LenMax) ? LenMax : len_q + 3'd1;
            for (int k = 0; k < 4; k++) begin
               cand_d[k] = cand_q[k] && (len_q < kw_len(2'(k)))
                           && (ch == kw_char(2'(k), len_q));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         len_q      <= 3'd0;
         cand_q     <= '1;
         sp_q       <= '0;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         len_q      <= len_d;
         cand_q     <= cand_d;
         sp_q       <= sp_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
      end
   end

   // Entries above sp are never read, so the stack needs no reset.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   always_comb begin
      bus.result   = !error_q && !would_err && (balance == '0);
      bus.depth    = sp_q;
      bus.error    = error_q;
      bus.overflow = overflow_q;
   end

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: DEPTH=16 and DEPTH=2 instances share one
// stream; a string-based reference model feeds a per-cycle scoreboard.
module tb_block_nest_checker;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   block_nest_checker_if #(.DW(5)) bus_a ();
   block_nest_checker_if #(.DW(2)) bus_b ();

   block_nest_checker #(.DEPTH(16), .DW(5)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   block_nest_checker #(.DEPTH(2), .DW(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   typedef struct {
      int inst;
      int res;
      int dep;
      int err;
      int ovf;
   } exp_t;

   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   int    m_cap[2] = '{16, 2};
   int    m_sp[2];
   int    m_err[2];
   int    m_ovf[2];
   int    m_stk[2][16];
   string m_word[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int kind_of(input string w);
      if (w == "begin") return 1;
      if (w == "end")   return 2;
      if (w == "fork")  return 3;
      if (w == "join")  return 4;
      return 0;
   endfunction

   task automatic model_reset(input int i);
      m_sp[i]   = 0;
      m_err[i]  = 0;
      m_ovf[i]  = 0;
      m_word[i] = "";
   endtask

   task automatic model_step(input int i, input byte c);
      int  k;
      byte lc;
      if (m_err[i] != 0) return;
      if (c == 8'h20 || c == 8'h0A) begin
         k         = kind_of(m_word[i]);
         m_word[i] = "";
         if (k == 1 || k == 3) begin
            if (m_sp[i] == m_cap[i]) begin
               m_err[i] = 1;
               m_ovf[i] = 1;
            end else begin
               m_stk[i][m_sp[i]] = (k == 3) ? 1 : 0;
               m_sp[i]++;
            end
         end else if (k == 2 || k == 4) begin
            if (m_sp[i] == 0) m_err[i] = 1;
            else if (m_stk[i][m_sp[i] - 1] != ((k == 4) ? 1 : 0)) m_err[i] = 1;
            else m_sp[i]--;
         end
      end else begin
         lc        = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
         m_word[i] = $sformatf("%s%c", m_word[i], lc);
      end
   endtask

   function automatic exp_t model_out(input int i);
      exp_t e;
      int   k, op, cl, we;
      k  = kind_of(m_word[i]);
      op = (k == 1 || k == 3) ? 1 : 0;
      cl = (k == 2 || k == 4) ? 1 : 0;
      we = 0;
      if (cl != 0) begin
         if (m_sp[i] == 0) we = 1;
         else if (m_stk[i][m_sp[i] - 1] != ((k == 4) ? 1 : 0)) we = 1;
      end
      if (op != 0 && m_sp[i] == m_cap[i]) we = 1;
      e.inst = i;
      e.res  = (m_err[i] == 0 && we == 0 && (m_sp[i] + op - cl) == 0) ? 1 : 0;
      e.dep  = m_sp[i];
      e.err  = m_err[i];
      e.ovf  = m_ovf[i];
      return e;
   endfunction

   task automatic compare(input exp_t e);
      logic [31:0] r, d, er, ov;
      if (e.inst == 0) begin
         r = 32'(bus_a.result); d = 32'(bus_a.depth); er = 32'(bus_a.error); ov = 32'(bus_a.overflow);
      end else begin
         r = 32'(bus_b.result); d = 32'(bus_b.depth); er = 32'(bus_b.error); ov = 32'(bus_b.overflow);
      end
      check_eq($sformatf("sb%0d.result", e.inst), r, e.res);
      check_eq($sformatf("sb%0d.depth", e.inst), d, e.dep);
      check_eq($sformatf("sb%0d.error", e.inst), er, e.err);
      check_eq($sformatf("sb%0d.overflow", e.inst), ov, e.ovf);
   endtask

   task automatic cycle(input logic rst_n, input logic v, input byte c);
      @(negedge clk);
      reset       = rst_n;
      bus_a.valid = v;
      bus_a.in    = c;
      bus_b.valid = v;
      bus_b.in    = c;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) model_reset(i);
         else if (v) model_step(i, c);
         sb_q.push_back(model_out(i));
      end
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) compare(sb_q.pop_front());
   endtask

   task automatic send_str(input string s);
      for (int j = 0; j < s.len(); j++) cycle(1'b1, 1'b1, s[j]);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) cycle(1'b1, 1'b0, 8'h00);
   endtask

   task automatic hold_reset(input int n);
      for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      reset       = 1'b0;
      bus_a.valid = 1'b0;
      bus_a.in    = 8'h00;
      bus_b.valid = 1'b0;
      bus_b.in    = 8'h00;

      // Reset, then idle
      hold_reset(2);
      idle(1);
      check_eq("rst.result", 32'(bus_a.result), 1);
      check_eq("rst.depth", 32'(bus_a.depth), 0);
      check_eq("rst.error", 32'(bus_a.error), 0);
      check_eq("rst.overflow", 32'(bus_a.overflow), 0);

      // Mixed nesting
      send_str("BEGI");
      check_eq("mix.pre_n", 32'(bus_a.result), 1);
      send_str("N");
      check_eq("mix.at_n", 32'(bus_a.result), 0);
      send_str(" ");
      check_eq("mix.d1", 32'(bus_a.depth), 1);
      send_str("fork ");
      check_eq("mix.d2", 32'(bus_a.depth), 2);
      send_str("Join ");
      check_eq("mix.d3", 32'(bus_a.depth), 1);
      send_str("en");
      check_eq("mix.at_en", 32'(bus_a.result), 0);
      send_str("d");
      check_eq("mix.at_d", 32'(bus_a.result), 1);
      check_eq("mix.depth_pre", 32'(bus_a.depth), 1);
      send_str(" ");
      check_eq("mix.d4", 32'(bus_a.depth), 0);

      // Type mismatch
      hold_reset(1);
      send_str("begin joi");
      send_str("n");
      check_eq("mm.at_n", 32'(bus_a.result), 0);
      send_str(" ");
      check_eq("mm.error", 32'(bus_a.error), 1);
      check_eq("mm.depth", 32'(bus_a.depth), 1);
      send_str("end ");
      check_eq("mm.error_late", 32'(bus_a.error), 1);
      check_eq("mm.result_late", 32'(bus_a.result), 0);

      // Near-miss words
      hold_reset(1);
      send_str("begi");
      send_str("n");
      check_eq("nm.at_n", 32'(bus_a.result), 0);
      send_str("x");
      check_eq("nm.at_x", 32'(bus_a.result), 1);
      send_str(" en");
      send_str("d");
      check_eq("nm.at_d", 32'(bus_a.result), 0);
      send_str("y");
      check_eq("nm.at_y", 32'(bus_a.result), 1);
      send_str("  forks ");
      check_eq("nm.depth", 32'(bus_a.depth), 0);
      check_eq("nm.error", 32'(bus_a.error), 0);

      // Overflow on the DEPTH=2 instance
      hold_reset(1);
      send_str("begin begin ");
      check_eq("ovf.depth2", 32'(bus_b.depth), 2);
      send_str("for");
      send_str("k");
      check_eq("ovf.at_k", 32'(bus_b.result), 0);
      send_str(" ");
      check_eq("ovf.error", 32'(bus_b.error), 1);
      check_eq("ovf.overflow", 32'(bus_b.overflow), 1);
      check_eq("ovf.depth", 32'(bus_b.depth), 2);
      check_eq("ovf.wide_ok", 32'(bus_a.overflow), 0);

      // Gaps in valid, then reset mid-word
      hold_reset(1);
      send_str("beg");
      idle(3);
      send_str("in ");
      check_eq("gap.depth", 32'(bus_a.depth), 1);
      send_str("en");
      hold_reset(1);
      send_str("d ");
      check_eq("gap.depth_rst", 32'(bus_a.depth), 0);
      check_eq("gap.error", 32'(bus_a.error), 0);
      check_eq("gap.result", 32'(bus_a.result), 1);

      // Case folding, LF delimiter and a non-letter inside a keyword
      send_str("FoRk\nbe9in jOIN\n");
      check_eq("lf.depth", 32'(bus_a.depth), 0);
      check_eq("lf.error", 32'(bus_a.error), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
